// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: default width,
// controller state encoding and counter width derivation.
package seq_mult_pkg;

  localparam int N_DEF = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_M   = 3'd1,
    LD_Q   = 3'd2,
    CALC   = 3'd3,
    OUT_HI = 3'd4,
    OUT_LO = 3'd5
  } state_t;

  // Iteration counter must hold values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Multiplier datapath: operand/accumulator registers, N+1-bit adder,
// right shifter, iteration counter and the result bus mux.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = cnt_width(N_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_m,
  input  logic         ld_q,
  input  logic         clr_a,
  input  logic         calc,
  input  logic         add,
  input  logic         out_en,
  input  logic         out_sel,
  input  logic [N-1:0] bus_in,
  output logic         q0,
  output logic         cnt_done,
  output logic [N-1:0] bus_out
);

  logic [N-1:0]  m;
  logic [N-1:0]  a;
  logic [N-1:0]  q;
  logic          c;
  logic [CW-1:0] cnt;
  logic [N:0]    sum;

  // c is always 0 entering an iteration, so {c,a} equals {0,a} on a no-add step.
  assign sum      = add ? ({1'b0, a} + {1'b0, m}) : {c, a};
  assign q0       = q[0];
  assign cnt_done = (cnt == CW'(N - 1));
  assign bus_out  = out_en ? (out_sel ? a : q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m   <= '0;
      a   <= '0;
      q   <= '0;
      c   <= 1'b0;
      cnt <= '0;
    end else begin
      if (ld_m) m <= bus_in;
      if (ld_q) q <= bus_in;
      if (clr_a) begin
        a   <= '0;
        c   <= 1'b0;
        cnt <= '0;
      end
      if (calc) begin
        {c, a, q} <= {1'b0, sum, q[N-1:1]};
        cnt       <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier: controller FSM plus datapath.
// Operands arrive serially on inBus; the 2N-bit product leaves on outBus, high half first.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] inBus,
  output logic [N-1:0] outBus,
  output logic         busy,
  output logic         out_valid,
  output logic         out_hi,
  output state_t       dbg_state
);

  localparam int CW = cnt_width(N);

  // Handshake: start is a request honoured only in IDLE; out_valid marks the two
  // result cycles (out_hi qualifies the upper half) and outBus is 0 otherwise.

  state_t state;
  logic   q0;
  logic   cnt_done;
  logic   ld_m;
  logic   ld_q;
  logic   calc;
  logic   out_en;
  logic   out_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= LD_M;
        LD_M:    state <= LD_Q;
        LD_Q:    state <= CALC;
        CALC:    if (cnt_done) state <= OUT_HI;
        OUT_HI:  state <= OUT_LO;
        OUT_LO:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ld_m    = (state == LD_M);
  assign ld_q    = (state == LD_Q);
  assign calc    = (state == CALC);
  assign out_sel = (state == OUT_HI);
  assign out_en  = (state == OUT_HI) || (state == OUT_LO);

  assign busy      = (state != IDLE);
  assign out_valid = out_en;
  assign out_hi    = out_sel;
  assign dbg_state = state;

  seq_mult_datapath #(
    .N  (N),
    .CW (CW)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .ld_m     (ld_m),
    .ld_q     (ld_q),
    .clr_a    (ld_q),
    .calc     (calc),
    .add      (calc && q0),
    .out_en   (out_en),
    .out_sel  (out_sel),
    .bus_in   (inBus),
    .q0       (q0),
    .cnt_done (cnt_done),
    .bus_out  (outBus)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: driver issues operand pairs and queues the
// hand-computed product halves; a negedge monitor pops and compares.
module tb_seq_multiplier;
  import seq_mult_pkg::*;

  localparam int N = 6;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] inBus;
  logic [N-1:0] outBus;
  logic         busy;
  logic         out_valid;
  logic         out_hi;
  state_t       dbg_state;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Entry: {out_hi, outBus}
  logic [N:0] exp_q[$];
  int         valid_run = 0;

  seq_multiplier #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inBus     (inBus),
    .outBus    (outBus),
    .busy      (busy),
    .out_valid (out_valid),
    .out_hi    (out_hi),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [N:0] e;
    if (out_valid) begin
      valid_run++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_hi", int'(out_hi), int'(e[N]));
        check(e[N] ? "product_hi" : "product_lo", int'(outBus), int'(e[N-1:0]));
      end
    end else begin
      if (valid_run != 0) check("valid_len", valid_run, 2);
      valid_run = 0;
      if (outBus != '0) check("bus_idle_zero", int'(outBus), 0);
    end
  end

  // ---------------- driver ----------------
  // mode 0: plain; 1: start pulsed in LD_Q, CALC and OUT_HI; 2: start raised in OUT_LO and left high.
  // cont=1: caller already left start=1 in an IDLE cycle, so the request is in flight.
  task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int mode, input bit cont, input string tag);
    int k;
    bit done;
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    if (!cont) begin
      @(negedge clk);
      start = 1'b1;
      inBus = '0;
    end
    exp_q.push_back({1'b1, p[2*N-1:N]});
    exp_q.push_back({1'b0, p[N-1:0]});
    k = 0;
    done = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      k++;
      inBus = (k == 1) ? a : (k == 2) ? b : '0;
      case (mode)
        1:       start = (k == 2) || (k == 5) || (k == N + 3);
        2:       start = (k == N + 4);
        default: start = 1'b0;
      endcase
    end
    if (!done) check({tag, "_busy_timeout"}, 1, 0);
    check({tag, "_busy_cycles"}, k, N + 4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    inBus = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_hi",    int'(out_hi), 0);
    check("rst_bus",   int'(outBus), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    run_mult(6'd5,  6'd3,  0, 1'b0, "m5x3");
    run_mult(6'd63, 6'd63, 0, 1'b0, "m63x63");
    run_mult(6'd37, 6'd41, 0, 1'b0, "m37x41");
    run_mult(6'd32, 6'd2,  0, 1'b0, "m32x2");
    run_mult(6'd0,  6'd45, 0, 1'b0, "m0x45");
    run_mult(6'd45, 6'd0,  0, 1'b0, "m45x0");

    // Asynchronous reset in the middle of CALC abandons the product.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    inBus = 6'd63;
    @(negedge clk);
    inBus = 6'd63;
    repeat (3) @(negedge clk);
    check("pre_rst_state", int'(dbg_state), int'(CALC));
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",  int'(busy), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_hi",    int'(out_hi), 0);
    check("midrst_bus",   int'(outBus), 0);
    check("midrst_state", int'(dbg_state), int'(IDLE));
    rst = 1'b0;
    inBus = '0;
    repeat (2) @(negedge clk);
    check("post_rst_state", int'(dbg_state), int'(IDLE));
    run_mult(6'd5, 6'd3, 0, 1'b0, "m5x3_after_rst");

    // Stray start pulses mid-operation are ignored.
    run_mult(6'd37, 6'd41, 1, 1'b0, "m37x41_pokes");
    @(negedge clk);
    check("poke_idle", int'(busy), 0);

    // start held through OUT_LO: next product begins after one IDLE cycle.
    run_mult(6'd5, 6'd3, 2, 1'b0, "m5x3_hold");
    check("b2b_idle_state", int'(dbg_state), int'(IDLE));
    run_mult(6'd7, 6'd9, 0, 1'b1, "m7x9_b2b");

    // Releasing reset with start already high acts as a normal start.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst_start_busy", int'(busy), 0);
    rst = 1'b0;
    run_mult(6'd63, 6'd63, 0, 1'b1, "m63x63_rst_start");

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
